// File: rtl/fp2_mult_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fp2_mult_scheduler
// Description : Shares one Fp^2 Montgomery multiplier pair (sub/add halves)
//               among N_REQ requesters. Define FP2_SCHED_ROUND_ROBIN_EN for
//               round-robin arbitration; fixed priority otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module fp2_mult_scheduler #(
    parameter int N_REQ          = 4,
    parameter int REQ_LOG        = $clog2(N_REQ),
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TIMEOUT_LOG    = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   mem_release,
    output logic [N_REQ-1:0]   grant,
    output logic [REQ_LOG-1:0] grant_idx,
    output logic [N_REQ-1:0]   req_done,
    output logic               mult_start,
    input  logic               mult_sub_done,
    input  logic               mult_add_done,
    output logic               busy,
    output logic               err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam logic [TIMEOUT_LOG-1:0] WD_LAST = TIMEOUT_LOG'(TIMEOUT_CYCLES - 1);
    localparam logic [REQ_LOG:0]       N_REQ_W = (REQ_LOG + 1)'(N_REQ);

    state_t                 state;
    logic                   sub_seen;
    logic                   add_seen;
    logic [TIMEOUT_LOG-1:0] wdog;

    logic                   sub_now;
    logic                   add_now;
    logic                   owner_release;

    logic [N_REQ-1:0]       req_rot;
    logic [REQ_LOG-1:0]     pick_base;
    logic [REQ_LOG-1:0]     pick_off;
    logic [REQ_LOG:0]       pick_sum;
    logic [REQ_LOG-1:0]     pick_idx;
    logic                   pick_valid;

`ifdef FP2_SCHED_ROUND_ROBIN_EN
    localparam logic [REQ_LOG-1:0] LAST_IDX = REQ_LOG'(N_REQ - 1);
    logic [REQ_LOG-1:0] rr_ptr;

    // Rotate so that bit 0 is the requester the pointer names.
    assign req_rot   = N_REQ'({req, req} >> rr_ptr);
    assign pick_base = rr_ptr;
`else
    assign req_rot   = req;
    assign pick_base = '0;
`endif

    always_comb begin
        pick_valid = 1'b0;
        pick_off   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                pick_valid = 1'b1;
                pick_off   = REQ_LOG'(k);
            end
        end
        pick_sum = {1'b0, pick_base} + {1'b0, pick_off};
        if (pick_sum >= N_REQ_W) begin
            pick_sum = pick_sum - N_REQ_W;
        end
        pick_idx = pick_sum[REQ_LOG-1:0];
    end

    assign sub_now       = sub_seen | mult_sub_done;
    assign add_now       = add_seen | mult_add_done;
    assign owner_release = |(mem_release & grant);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            grant      <= '0;
            grant_idx  <= '0;
            req_done   <= '0;
            mult_start <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            sub_seen   <= 1'b0;
            add_seen   <= 1'b0;
            wdog       <= '0;
`ifdef FP2_SCHED_ROUND_ROBIN_EN
            rr_ptr     <= '0;
`endif
        end else begin
            req_done   <= '0;
            mult_start <= 1'b0;

            // Any done pulse that is not part of an active RUN is a protocol error.
            if ((state != S_RUN) && (mult_sub_done || mult_add_done)) begin
                err <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        grant      <= N_REQ'(1) << pick_idx;
                        grant_idx  <= pick_idx;
                        mult_start <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_START;
                    end
                end

                S_START: begin
                    sub_seen <= 1'b0;
                    add_seen <= 1'b0;
                    wdog     <= '0;
                    state    <= S_RUN;
                end

                S_RUN: begin
                    if ((mult_sub_done && sub_seen) || (mult_add_done && add_seen)) begin
                        err <= 1'b1;
                    end
                    sub_seen <= sub_now;
                    add_seen <= add_now;
                    wdog     <= wdog + TIMEOUT_LOG'(1);
                    // A pair completing on the last watchdog cycle still counts as success.
                    if (sub_now && add_now) begin
                        req_done <= grant;
                        state    <= S_HOLD;
                    end else if (wdog == WD_LAST) begin
                        err      <= 1'b1;
                        req_done <= grant;
                        state    <= S_HOLD;
                    end
                end

                S_HOLD: begin
                    if (owner_release) begin
                        grant     <= '0;
                        grant_idx <= '0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
`ifdef FP2_SCHED_ROUND_ROBIN_EN
                        rr_ptr    <= (grant_idx == LAST_IDX) ? '0 : grant_idx + REQ_LOG'(1);
`endif
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp2_mult_scheduler.sv
`default_nettype none
// Scoreboard bench for fp2_mult_scheduler: directed plus randomized transactions
// checked against a cycle-level timeline model of the arbitration rules.
module tb_fp2_mult_scheduler;

    localparam int N  = 4;
    localparam int TO = 64;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic [3:0] req   = '0;
    logic [3:0] rel   = '0;
    logic       sub_d = 1'b0;
    logic       add_d = 1'b0;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic [3:0] req_done;
    logic       mult_start;
    logic       busy;
    logic       err;

    fp2_mult_scheduler #(
        .N_REQ(N), .REQ_LOG(2), .TIMEOUT_CYCLES(TO), .TIMEOUT_LOG(7)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .mem_release(rel),
        .grant(grant), .grant_idx(grant_idx), .req_done(req_done),
        .mult_start(mult_start), .mult_sub_done(sub_d), .mult_add_done(add_d),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int       cyc;
        logic [3:0] vec;
        int       idx;
        logic     err_exp;
    } exp_t;

    exp_t q_grant[$];
    exp_t q_done[$];
    int   q_start[$];
    int   q_rel[$];

    int   total = 0;
    int   bad   = 0;
    int   ptr   = 0;
    logic err_m = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // First requester at or after the pointer, wrapping around.
    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Monitor: pops expectations whenever the DUT presents an event.
    logic [3:0] prev_grant = '0;
    always @(negedge clk) begin
        exp_t e;
        int   c;
        if (grant !== prev_grant) begin
            if (prev_grant != 0) begin
                if (q_rel.size() == 0) check("unexpected_release", cyc, -1);
                else begin
                    c = q_rel.pop_front();
                    check("release_cycle", cyc, c);
                    check("release_grant", int'(grant), 0);
                    check("release_idx", int'(grant_idx), 0);
                    check("release_busy", int'(busy), 0);
                end
            end
            if (grant != 0) begin
                if (q_grant.size() == 0) check("unexpected_grant", int'(grant), 0);
                else begin
                    e = q_grant.pop_front();
                    check("grant_cycle", cyc, e.cyc);
                    check("grant_vec", int'(grant), int'(e.vec));
                    check("grant_idx", int'(grant_idx), e.idx);
                    check("grant_busy", int'(busy), 1);
                end
            end
            prev_grant = grant;
        end
        if (mult_start) begin
            if (q_start.size() == 0) check("unexpected_start", cyc, -1);
            else begin
                c = q_start.pop_front();
                check("start_cycle", cyc, c);
            end
        end
        if (req_done != 0) begin
            if (q_done.size() == 0) check("unexpected_done", int'(req_done), 0);
            else begin
                e = q_done.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("done_vec", int'(req_done), int'(e.vec));
                check("done_err", int'(err), int'(e.err_exp));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = '0;
        repeat (n) step();
    endtask

    // One full transaction; called in a cycle where the model says the DUT is idle.
    task automatic txn(input logic [3:0] rv, input int ds, input int da, input int ds2,
                       input int rd, input bit wrong);
        int   t, owner, s, sub_c, add_c, sub2_c, comp, dc, r, other;
        bit   tmo;
        logic e_done;
        exp_t e;
        t     = cyc;
        req   = rv;
        owner = pick(rv, ptr);
        s     = t + 1;
        e.cyc = s; e.vec = 4'(1 << owner); e.idx = owner; e.err_exp = 1'b0;
        q_grant.push_back(e);
        q_start.push_back(s);
        sub_c  = s + ds;
        add_c  = s + da;
        sub2_c = (ds2 > 0) ? s + ds2 : -1;
        comp   = (sub_c > add_c) ? sub_c : add_c;
        tmo    = (comp > s + TO);
        dc     = tmo ? s + TO + 1 : comp + 1;
        e_done = err_m | tmo | (sub2_c > 0 && sub2_c < dc);
        e.cyc = dc; e.err_exp = e_done;
        q_done.push_back(e);
        r = dc + rd;
        if (sub_c > r) r = sub_c;
        if (add_c > r) r = add_c;
        if (sub2_c > r) r = sub2_c;
        q_rel.push_back(r + 1);
        other = (owner + 2) % N;
        for (int c = t; c <= r; c++) begin
            sub_d = (c == sub_c) || (c == sub2_c);
            add_d = (c == add_c);
            rel   = ((c == r) ? e.vec : 4'b0) | ((wrong && c == dc) ? 4'(1 << other) : 4'b0);
            step();
        end
        sub_d = 1'b0;
        add_d = 1'b0;
        rel   = '0;
        err_m = e_done | (sub_c >= dc) | (add_c >= dc) | (sub2_c >= dc);
`ifdef FP2_SCHED_ROUND_ROBIN_EN
        ptr = (owner + 1) % N;
`endif
    endtask

    initial begin
        logic [3:0] rv;
        int ds, da, ds2, t;

        repeat (3) step();
        check("reset_grant", int'(grant), 0);
        check("reset_idx", int'(grant_idx), 0);
        check("reset_done", int'(req_done), 0);
        check("reset_start", int'(mult_start), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_err", int'(err), 0);
        rst = 1'b0;

        txn(4'b0100, 50, 52, 0, 3, 1'b0);
        txn(4'b0011, 5, 5, 0, 2, 1'b0);
        txn(4'b0010, 9, 4, 0, 3, 1'b1);
        repeat (5) txn(4'b1111, 6, 8, 0, 2, 1'b0);
        txn(4'b1000, 5, TO, 0, 1, 1'b0);
        txn(4'b0100, 10, TO + 1, 0, 2, 1'b0);
        idle(2);

        for (int i = 0; i < 30; i++) begin
            rv  = 4'($urandom_range(15, 1));
            ds  = $urandom_range(30, 1);
            da  = ($urandom_range(3, 0) == 0) ? ds : $urandom_range(30, 1);
            if ($urandom_range(9, 0) == 0) da = $urandom_range(TO + 6, TO - 4);
            ds2 = ($urandom_range(9, 0) == 0) ? ds + $urandom_range(5, 1) : 0;
            txn(rv, ds, da, ds2, $urandom_range(4, 0), 1'($urandom_range(1, 0)));
            if ($urandom_range(4, 0) == 0) idle($urandom_range(3, 1));
        end

        // Asynchronous reset ten cycles after mult_start.
        t   = cyc;
        req = 4'b0100;
        q_grant.push_back('{t + 1, 4'b0100, 2, 1'b0});
        q_start.push_back(t + 1);
        repeat (11) step();
        q_rel.push_back(cyc);
        rst = 1'b1;
        req = '0;
        #1;
        check("async_rst_grant", int'(grant), 0);
        check("async_rst_idx", int'(grant_idx), 0);
        check("async_rst_done", int'(req_done), 0);
        check("async_rst_start", int'(mult_start), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_err", int'(err), 0);
        step();
        step();
        rst   = 1'b0;
        err_m = 1'b0;
        ptr   = 0;

        txn(4'b1001, 3, 4, 0, 1, 1'b0);
        txn(4'b0001, 7, 7, 0, 2, 1'b1);
        txn(4'b0110, 12, 2, 0, 0, 1'b0);
        idle(4);

        check("leftover_grant", q_grant.size(), 0);
        check("leftover_start", q_start.size(), 0);
        check("leftover_done", q_done.size(), 0);
        check("leftover_release", q_rel.size(), 0);
        check("final_err", int'(err), int'(err_m));
        check("final_busy", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp2_mult_scheduler.md
# fp2_mult_scheduler

Arbiter and sequencer that shares one Fp^2 Montgomery multiplier pair (subtraction half and addition half, both started together) among up to N_REQ software/datapath requesters. It picks a requester, issues a single start to both halves, and waits for both completion pulses. It then signals completion to the owner and keeps ownership of the operand and result memories with that requester until it releases them. It sits between the vOW controller/requesters and the two multiplier instances; grant_idx drives the external operand/result memory muxes.

## Interface
- N_REQ, 4: number of requesters, 2..16.
- REQ_LOG, `CLOG2(N_REQ): width of grant index.
- TIMEOUT_CYCLES, 4096: max cycles from mult_start to both halves done before abort.
- TIMEOUT_LOG, `CLOG2(TIMEOUT_CYCLES+1): width of watchdog counter.

- clk  in  1  clock; single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- req  in  N_REQ  level request per requester; held until its done pulse.
- release  in  N_REQ  one-cycle pulse; owner returns memories after reading the result.
- grant  out  N_REQ  one-hot owner; all-zero when idle.
- grant_idx  out  REQ_LOG  binary index of owner; 0 when idle.
- req_done  out  N_REQ  one-cycle pulse to owner when the result is valid.
- mult_start  out  1  one-cycle start to both multiplier halves.
- mult_sub_done  in  1  one-cycle done from the subtraction half.
- mult_add_done  in  1  one-cycle done from the addition half.
- busy  out  1  high whenever state != IDLE.
- err  out  1  sticky; set on timeout or stray done; cleared only by rst.

## Operation
- FSM states: IDLE, START, RUN, HOLD.
- IDLE: if any req bit is set, select a winner and register grant/grant_idx, then go to START. Otherwise stay.
- START: mult_start=1 for exactly this cycle. Clear sub_seen, add_seen and the watchdog counter. Go to RUN.
- RUN: latch sub_seen on mult_sub_done and add_seen on mult_add_done. The two pulses may arrive in any order or in the same cycle. The watchdog increments every RUN cycle.
  - Once both are seen, or the current-cycle pulse completes the pair: req_done[grant_idx]=1 for one cycle, go to HOLD.
  - If the watchdog reaches TIMEOUT_CYCLES: set err, pulse req_done[grant_idx], go to HOLD. This is an abort.
- HOLD: grant is held. Go to IDLE only on release[grant_idx]. Release bits of non-owners are ignored in every state.
- A mult_*_done outside RUN, or a repeated done within one RUN, sets err and is otherwise ignored.
- Selection is fixed priority, lowest index wins, unless the round-robin feature is built in (see Configuration).
- Deasserting req while granted does not abort the operation. The operation completes and waits for release.

## Timing
- Reset values: grant=0, grant_idx=0, req_done=0, mult_start=0, busy=0, err=0, state=IDLE, rr pointer=0.
- Asynchronous reset takes effect immediately, including mid-RUN. The multiplier halves are reset by the same rst.
- Latency:
  - req seen in IDLE at cycle t: grant valid at t+1, mult_start at t+1 (START), RUN from t+2.
  - Completing done pulse at cycle d: req_done at d+1, HOLD from d+1.
- Release at cycle r: state is IDLE at r+1, grant=0 at r+1. Next grant at r+2 at the earliest. A requester never sees a grant glitch.
- All outputs are registered. There is no combinational path from req/release/done to any output.

## Configuration
- FP2_SCHED_ROUND_ROBIN_EN defined:
  - Round-robin arbitration with a pointer register. Search starts at pointer, wraps N_REQ-1 -> 0.
  - On leaving HOLD, pointer = grant_idx+1 mod N_REQ.
- Not defined: fixed priority, lowest index wins. The pointer register is not instantiated.

## Test plan
- Single request: N_REQ=4, req=4'b0100, sub_done at start+50, add_done at start+52 -> grant=4'b0100 and grant_idx=2 one cycle after req, a single mult_start, req_done[2] one cycle after add_done, grant held until release[2].
- Simultaneous dones: both done pulses in the same cycle -> exactly one req_done pulse next cycle, err=0.
- Contention, round-robin built in: req=4'b1111 held, each owner releases 3 cycles after its req_done -> grant order 0,1,2,3,0. Without the macro the order is 0,0,0 (requester 0 re-requests).
- Wrong release: in HOLD with owner 1, pulse release[3] -> no state change. Then release[1] -> grant=0 next cycle.
- Timeout: TIMEOUT_CYCLES=16, only sub_done arrives -> err=1 and req_done pulse at the 16th RUN cycle, then HOLD. A later stray add_done keeps err=1.
- Reset mid-RUN: assert rst 10 cycles after mult_start -> all outputs 0 without waiting for a clock edge. After deassert, req=4'b0001 is served normally.
